// File: rtl/mdu_pkg.sv
// Shared types for the MIPS multiply/divide unit: opcode encoding, FSM states,
// divide iteration count and small opcode-class helpers.
// MDU_MADD_EN: when defined, MADD/MADDU/MSUB/MSUBU join the multiply class.
package mdu_pkg;

  // Radix-2 restoring divide: one quotient bit per cycle.
  localparam int DIV_ITERS = 32;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } mdu_state_t;

  // Signed flavour of the multiply / divide / accumulate ops.
  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Ops that take the one-cycle MUL path.
  function automatic logic op_is_mul(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops that stall the pipeline while they are presented.
  function automatic logic op_is_long(input logic [3:0] op);
    return op_is_mul(op) || op_is_div(op);
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Purpose : 32-bit restoring divider, one quotient bit per cycle, with sign fix-up.
// Latency : start at edge E; done_o high in the ITERS-th run cycle, results valid then.
// Backpr. : none; flush_i aborts a running divide, start_i is only honoured by the owner when idle.
// Ports   : clk, reset (sync, active high), start_i/flush_i control, signed_i,
//           dividend_i/divisor_i operands (sampled on start_i), done_o, quot_o, rem_o.
module div_radix2
  import mdu_pkg::*;
#(
  parameter int ITERS = DIV_ITERS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int            CW   = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   quo_q, quo_d;   // dividend shifts out the top, quotient shifts in
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   dvs_q, dvs_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;

  logic          a_neg, b_neg;
  logic [32:0]   rem_sh;
  logic          take;
  logic [31:0]   quo_step, rem_step;

  assign a_neg = signed_i & dividend_i[31];
  assign b_neg = signed_i & divisor_i[31];

  // One restoring step. rem_sh can exceed 32 bits, so the compare is 33 wide;
  // after a successful subtract the result is below the divisor and fits 32.
  always_comb begin
    rem_sh   = {rem_q, quo_q[31]};
    take     = (rem_sh >= {1'b0, dvs_q});
    rem_step = take ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
    quo_step = {quo_q[30:0], take};
  end

  always_comb begin
    run_d     = run_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (flush_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      // Magnitudes only; 0x80000000 stays 0x80000000 which is its correct magnitude.
      run_d     = 1'b1;
      cnt_d     = '0;
      quo_d     = a_neg ? (~dividend_i + 32'd1) : dividend_i;
      dvs_d     = b_neg ? (~divisor_i + 32'd1) : divisor_i;
      rem_d     = '0;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
    end else if (run_q) begin
      quo_d = quo_step;
      rem_d = rem_step;
      if (cnt_q == LAST) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Results are taken from the final step combinationally so the owner can
  // capture them on the same edge the last iteration would have been stored.
  assign done_o = run_q && (cnt_q == LAST);
  assign quot_o = neg_quo_q ? (~quo_step + 32'd1) : quo_step;
  assign rem_o  = neg_rem_q ? (~rem_step + 32'd1) : rem_step;

endmodule

// File: rtl/mul_div_unit.sv
// Purpose : MIPS multiply/divide unit feeding the HI/LO register file (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Latency : MTHI/MTLO and divide-by-zero write back at N+1, multiply at N+2, divide at N+33.
// Backpr. : busy stalls upstream during MUL/DIV and while a multiply/divide op is presented.
// Ports   : clk, reset (sync, active high); op_valid/op/src_a/src_b request; cur_hi/cur_lo
//           current HI/LO; flush cancels in-flight work; busy; wb_hi_en/wb_lo_en/wb_hi/wb_lo.
// Config  : MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU with forwarding of a just-written HI/LO.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int DIV_ITERS = mdu_pkg::DIV_ITERS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  input  logic        flush,
  output logic        busy,
  output logic        wb_hi_en,
  output logic        wb_lo_en,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo
);

  mdu_state_t  state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;

  logic [31:0] wb_hi_q, wb_hi_d, wb_lo_q, wb_lo_d;
  logic        wb_hi_en_q, wb_hi_en_d, wb_lo_en_q, wb_lo_en_d;

  logic        accept, div_by_zero, div_start;
  logic        div_done;
  logic [31:0] div_quot, div_rem;

  logic        mul_signed;
  logic [63:0] a_ext, b_ext, prod, mul_res;

  // A new op is only taken when idle or in the write-back cycle; flush wins.
  assign accept      = ((state_q == ST_IDLE) || (state_q == ST_OUT)) && op_valid && !flush;
  assign div_by_zero = (src_b == 32'd0);
  assign div_start   = accept && op_is_div(op) && !div_by_zero;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_OUT: begin
          state_d = ST_IDLE;
          if (accept) begin
            if (op_is_mul(op))                  state_d = ST_MUL;
            else if (op_is_div(op))             state_d = div_by_zero ? ST_OUT : ST_DIV;
            else if (op == OP_MTHI || op == OP_MTLO) state_d = ST_OUT;
          end
        end
        ST_MUL:  state_d = ST_OUT;
        ST_DIV:  state_d = div_done ? ST_OUT : ST_DIV;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // busy drops in OUT so the pipeline advances in the same cycle HI/LO is written.
  always_comb begin
    busy = 1'b0;
    case (state_q)
      ST_MUL, ST_DIV:  busy = 1'b1;
      ST_IDLE, ST_OUT: busy = op_valid && op_is_long(op);
      default:         busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------- operands
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= src_a;
      b_q  <= src_b;
    end
  end

  // -------------------------------------------------------- multiplier
  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  assign mul_signed = op_is_signed(op_q);
  assign a_ext      = {{32{mul_signed & a_q[31]}}, a_q};
  assign b_ext      = {{32{mul_signed & b_q[31]}}, b_q};
  assign prod       = a_ext * b_ext;

`ifdef MDU_MADD_EN
  logic [31:0] fwd_hi, fwd_lo;
  logic [31:0] base_hi_q, base_lo_q;

  // The HI/LO file has not absorbed this cycle's write yet, so take the
  // value being written instead of the stale read port.
  assign fwd_hi = ((state_q == ST_OUT) && wb_hi_en_q) ? wb_hi_q : cur_hi;
  assign fwd_lo = ((state_q == ST_OUT) && wb_lo_en_q) ? wb_lo_q : cur_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      base_hi_q <= '0;
      base_lo_q <= '0;
    end else if (accept) begin
      base_hi_q <= fwd_hi;
      base_lo_q <= fwd_lo;
    end
  end

  always_comb begin
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {base_hi_q, base_lo_q} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {base_hi_q, base_lo_q} - prod;
      default:           mul_res = prod;
    endcase
  end
`else
  // Without accumulate ops the current HI/LO values have no consumer.
  logic unused_cur;
  assign unused_cur = ^{cur_hi, cur_lo};
  assign mul_res    = prod;
`endif

  // ----------------------------------------------------------- divider
  div_radix2 #(
    .ITERS (DIV_ITERS)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .flush_i    (flush),
    .signed_i   (op == OP_DIV),
    .dividend_i (src_a),
    .divisor_i  (src_b),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // -------------------------------------------------------- write-back
  // Data registers hold their last value; enables are single-cycle pulses.
  always_comb begin
    wb_hi_d    = wb_hi_q;
    wb_lo_d    = wb_lo_q;
    wb_hi_en_d = 1'b0;
    wb_lo_en_d = 1'b0;
    if (!flush) begin
      if (accept) begin
        if (op == OP_MTHI) begin
          wb_hi_d    = src_a;
          wb_hi_en_d = 1'b1;
        end else if (op == OP_MTLO) begin
          wb_lo_d    = src_a;
          wb_lo_en_d = 1'b1;
        end else if (op_is_div(op) && div_by_zero) begin
          wb_hi_d    = src_a;
          wb_lo_d    = 32'hFFFF_FFFF;
          wb_hi_en_d = 1'b1;
          wb_lo_en_d = 1'b1;
        end
      end else if (state_q == ST_MUL) begin
        wb_hi_d    = mul_res[63:32];
        wb_lo_d    = mul_res[31:0];
        wb_hi_en_d = 1'b1;
        wb_lo_en_d = 1'b1;
      end else if ((state_q == ST_DIV) && div_done) begin
        wb_hi_d    = div_rem;
        wb_lo_d    = div_quot;
        wb_hi_en_d = 1'b1;
        wb_lo_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_hi_q    <= '0;
      wb_lo_q    <= '0;
      wb_hi_en_q <= 1'b0;
      wb_lo_en_q <= 1'b0;
    end else begin
      wb_hi_q    <= wb_hi_d;
      wb_lo_q    <= wb_lo_d;
      wb_hi_en_q <= wb_hi_en_d;
      wb_lo_en_q <= wb_lo_en_d;
    end
  end

  assign wb_hi    = wb_hi_q;
  assign wb_lo    = wb_lo_q;
  assign wb_hi_en = wb_hi_en_q;
  assign wb_lo_en = wb_lo_en_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed ops, a per-cycle schedule of expected HI/LO
// writes and busy built from plain arithmetic, and a negedge compare process.
module tb_mul_div_unit;

  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] src_a, src_b, cur_hi, cur_lo;
  logic        flush;
  logic        busy, wb_hi_en, wb_lo_en;
  logic [31:0] wb_hi, wb_lo;

  mul_div_unit #(.DIV_ITERS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cur_hi   (cur_hi),
    .cur_lo   (cur_lo),
    .flush    (flush),
    .busy     (busy),
    .wb_hi_en (wb_hi_en),
    .wb_lo_en (wb_lo_en),
    .wb_hi    (wb_hi),
    .wb_lo    (wb_lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Expected behaviour per cycle.
  bit          exp_busy [MAXC];
  bit          wr_h_en  [MAXC];
  bit          wr_l_en  [MAXC];
  logic [31:0] wr_h_val [MAXC];
  logic [31:0] wr_l_val [MAXC];

  bit          checking = 1'b0;
  bit          prev_rst = 1'b1;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Architectural result of one op, from the ISA rules with wide arithmetic.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output bit he, output bit le, output bit lng,
                       output logic [31:0] h, output logic [31:0] l, output int lat);
    longint      sa, sb, ua, ub;
    logic [63:0] p, q, r;
    he = 0; le = 0; lng = 0; h = '0; l = '0; lat = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (o)
      4'd0, 4'd1: begin
        if (o == 4'd0) p = 64'(sa * sb);
        else           p = {32'd0, a} * {32'd0, b};
        h = p[63:32]; l = p[31:0]; he = 1; le = 1; lng = 1; lat = 2;
      end
      4'd2, 4'd3: begin
        he = 1; le = 1; lng = 1;
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; lat = 1;
        end else begin
          if (o == 4'd2) begin q = 64'(sa / sb); r = 64'(sa % sb); end
          else           begin q = 64'(ua / ub); r = 64'(ua % ub); end
          l = q[31:0]; h = r[31:0]; lat = 33;
        end
      end
      4'd4: begin h = a; he = 1; lat = 1; end
      4'd5: begin l = a; le = 1; lat = 1; end
      default: lat = 0;
    endcase
  endtask

  task automatic sched(input int n, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bit he, le, lng;
    logic [31:0] h, l;
    int lat;
    model(o, a, b, he, le, lng, h, l, lat);
    if (lat > 0) begin
      wr_h_en[n+lat] = he; wr_h_val[n+lat] = h;
      wr_l_en[n+lat] = le; wr_l_val[n+lat] = l;
    end
    if (lng) for (int k = n; k < n + lat; k++) exp_busy[k] = 1'b1;
  endtask

  task automatic cancel_from(input int c);
    for (int k = c; k < MAXC; k++) begin
      exp_busy[k] = 1'b0; wr_h_en[k] = 1'b0; wr_l_en[k] = 1'b0;
    end
  endtask

  // Drive one op for the current cycle; returns one cycle later with op_valid low.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    sched(cyc, o, a, b);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Compare process: every cycle once out of the first reset.
  always @(negedge clk) begin
    if (checking && cyc < MAXC) begin
      if (prev_rst) begin m_hi = 32'd0; m_lo = 32'd0; end
      if (wr_h_en[cyc]) m_hi = wr_h_val[cyc];
      if (wr_l_en[cyc]) m_lo = wr_l_val[cyc];
      chk("busy",     {31'd0, busy},     {31'd0, exp_busy[cyc]});
      chk("wb_hi_en", {31'd0, wb_hi_en}, {31'd0, wr_h_en[cyc]});
      chk("wb_lo_en", {31'd0, wb_lo_en}, {31'd0, wr_l_en[cyc]});
      chk("wb_hi",    wb_hi, m_hi);
      chk("wb_lo",    wb_lo, m_lo);
    end
    prev_rst = reset;
  end

  initial begin : stim
    bit he, le, lng;
    logic [31:0] h, l;
    int lat;

    reset = 1'b1; op_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
    cur_hi = 32'h0000_AAAA; cur_lo = 32'h0000_0100; flush = 1'b0;

    // Pin the model against hand-computed values.
    model(4'd0, 32'hFFFF_FFFF, 32'd2, he, le, lng, h, l, lat);
    chk("model_mult_hi", h, 32'hFFFF_FFFF); chk("model_mult_lo", l, 32'hFFFF_FFFE);
    model(4'd1, 32'hFFFF_FFFF, 32'd2, he, le, lng, h, l, lat);
    chk("model_multu_hi", h, 32'h0000_0001); chk("model_multu_lo", l, 32'hFFFF_FFFE);
    model(4'd2, 32'hFFFF_FFF9, 32'd2, he, le, lng, h, l, lat);
    chk("model_div_lo", l, 32'hFFFF_FFFD); chk("model_div_hi", h, 32'hFFFF_FFFF);
    chk("model_div_lat", 32'(lat), 32'd33);
    model(4'd3, 32'd100, 32'd7, he, le, lng, h, l, lat);
    chk("model_divu_lo", l, 32'd14); chk("model_divu_hi", h, 32'd2);
    model(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, he, le, lng, h, l, lat);
    chk("model_ovf_lo", l, 32'h8000_0000); chk("model_ovf_hi", h, 32'd0);

    @(posedge clk); #1;
    checking = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_hi", wb_hi, 32'd0);
    chk("rst_wb_lo", wb_lo, 32'd0);
    @(posedge clk); #1;

    // Multiply, signed and unsigned, plus a multiply accepted in OUT.
    issue(4'd0, 32'hFFFF_FFFF, 32'd2);  idle(3);
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);  idle(3);
    issue(4'd1, 32'd3, 32'd4);          idle(1);
    issue(4'd0, 32'hFFFF_FFFD, 32'd4);  idle(3);

    // Divide.
    issue(4'd2, 32'hFFFF_FFF9, 32'd2);  idle(35);
    issue(4'd3, 32'd100, 32'd7);        idle(35);
    issue(4'd2, 32'd100, 32'hFFFF_FFF9); idle(35);
    issue(4'd3, 32'd5, 32'd0);          idle(2);
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF); idle(35);

    // op_valid during DIV is ignored.
    issue(4'd3, 32'd50, 32'd5);
    op_valid = 1'b1; op = 4'd0; src_a = 32'd9; src_b = 32'd9;
    repeat (5) begin @(posedge clk); #1; end
    idle(30);

    // Flush in DIV cycle 10, then a multiply.
    issue(4'd2, 32'd1000, 32'd3);
    idle(10);
    flush = 1'b1;
    cancel_from(cyc + 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    idle(40);
    issue(4'd1, 32'd3, 32'd4); idle(3);

    // Op presented together with flush is not accepted.
    exp_busy[cyc] = 1'b1;
    op_valid = 1'b1; op = 4'd0; src_a = 32'd5; src_b = 32'd6; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle(4);

    // MTHI then MTLO in its OUT cycle.
    issue(4'd4, 32'h0000_1234, 32'd0);
    issue(4'd5, 32'h0000_5678, 32'd0);
    idle(3);

`ifdef MDU_MADD_EN
    // MADDU in OUT after MTHI 0: HI forwarded, LO from the file.
    issue(4'd4, 32'd0, 32'd0);
    wr_h_en[cyc+2] = 1'b1; wr_h_val[cyc+2] = 32'd0;
    wr_l_en[cyc+2] = 1'b1; wr_l_val[cyc+2] = cur_lo + 32'd12;
    exp_busy[cyc] = 1'b1; exp_busy[cyc+1] = 1'b1;
    op_valid = 1'b1; op = 4'd7; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    idle(4);
`else
    // Accumulate opcodes are no-ops in this build.
    issue(4'd6, 32'd3, 32'd4); idle(3);
    issue(4'd9, 32'd3, 32'd4); idle(3);
`endif
    // Unknown opcode.
    issue(4'd13, 32'd7, 32'd7); idle(3);

    // Reset mid-MULT.
    issue(4'd0, 32'd7, 32'd9);
    reset = 1'b1;
    cancel_from(cyc + 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmul_busy", {31'd0, busy}, 32'd0);
    chk("rstmul_hi_en", {31'd0, wb_hi_en}, 32'd0);
    chk("rstmul_wb_lo", wb_lo, 32'd0);
    @(posedge clk); #1;
    idle(2);

    // Write something non-zero, then reset mid-DIV.
    issue(4'd5, 32'hCAFE_0001, 32'd0); idle(2);
    issue(4'd2, 32'd100, 32'd3);
    idle(14);
    reset = 1'b1;
    cancel_from(cyc + 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstdiv_busy", {31'd0, busy}, 32'd0);
    chk("rstdiv_lo_en", {31'd0, wb_lo_en}, 32'd0);
    chk("rstdiv_wb_lo", wb_lo, 32'd0);
    chk("rstdiv_wb_hi", wb_hi, 32'd0);
    @(posedge clk); #1;
    idle(40);

    // Unit recovers after reset.
    issue(4'd3, 32'd100, 32'd7); idle(36);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
